aes_key_sched_ctrl: RTL and testbench

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_key_sched_ctrl.sv | 130 +++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// Sequencing controller for an external AES key-expansion datapath: captures the
// cipher key, steps the key-gen one round at a time and hands out round keys over valid/ready.
module aes_key_sched_ctrl #(
  parameter int NRND = 10
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [127:0] key_i,
  input  logic [127:0] kg_key_i,
  output logic [127:0] kg_key_o,
  output logic         kg_en_o,
  output logic         kg_gen_key_o,
  output logic         kg_next_rnd_o,
  output logic [7:0]   kg_rcon_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         busy_o,
  output logic         done_o
);

  // state | meaning
  // IDLE  | no schedule; waits for start_i
  // PRES  | round key r presented on rk_o, waiting for rk_ready_i
  // CALC  | one-cycle key-gen step producing round key r
  typedef enum logic [1:0] {IDLE, PRES, CALC} state_t;

  localparam logic [3:0] LAST = 4'(NRND);

  state_t       state;
  logic [127:0] key_q;
  logic [3:0]   r;

  function automatic logic [7:0] rcon_f(input logic [3:0] n);
    case (n)
      4'd1:    rcon_f = 8'h01;
      4'd2:    rcon_f = 8'h02;
      4'd3:    rcon_f = 8'h04;
      4'd4:    rcon_f = 8'h08;
      4'd5:    rcon_f = 8'h10;
      4'd6:    rcon_f = 8'h20;
      4'd7:    rcon_f = 8'h40;
      4'd8:    rcon_f = 8'h80;
      4'd9:    rcon_f = 8'h1b;
      4'd10:   rcon_f = 8'h36;
      default: rcon_f = 8'h00;
    endcase
  endfunction

  assign kg_key_o = key_q;
  // Round 0 is the cipher key itself; later rounds come straight from the key-gen register.
  assign rk_o     = rk_valid_o ? ((r == 4'd0) ? key_q : kg_key_i) : '0;
  assign rk_idx_o = rk_valid_o ? r : 4'd0;

  always_ff @(posedge clk) begin
    if (nrst) begin
      state         <= IDLE;
      key_q         <= '0;
      r             <= '0;
      rk_valid_o    <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      kg_en_o       <= 1'b0;
      kg_gen_key_o  <= 1'b0;
      kg_next_rnd_o <= 1'b0;
      kg_rcon_o     <= 8'h00;
    end else begin
      done_o        <= 1'b0;
      kg_en_o       <= 1'b0;
      kg_gen_key_o  <= 1'b0;
      kg_next_rnd_o <= 1'b0;
      kg_rcon_o     <= 8'h00;
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= PRES;
            key_q      <= key_i;
            r          <= 4'd0;
            rk_valid_o <= 1'b1;
            busy_o     <= 1'b1;
          end
        end
        PRES: begin
          if (abort_i) begin
            state      <= IDLE;
            r          <= 4'd0;
            rk_valid_o <= 1'b0;
            busy_o     <= 1'b0;
          end else if (rk_ready_i) begin
            rk_valid_o <= 1'b0;
            if (r == LAST) begin
              state  <= IDLE;
              r      <= 4'd0;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              // Enable and selects are set up here so the key-gen fires during CALC.
              state         <= CALC;
              r             <= r + 4'd1;
              kg_en_o       <= 1'b1;
              kg_gen_key_o  <= 1'b1;
              kg_next_rnd_o <= (r != 4'd0);
              kg_rcon_o     <= rcon_f(r + 4'd1);
            end
          end
        end
        CALC: begin
          if (abort_i) begin
            state      <= IDLE;
            r          <= 4'd0;
            rk_valid_o <= 1'b0;
            busy_o     <= 1'b0;
          end else begin
            state      <= PRES;
            rk_valid_o <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          rk_valid_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: models the key-gen datapath with a real AES S-box and
// checks the round-key stream against a transaction-level schedule model.
module tb_aes_key_sched_ctrl;
  localparam int NRND = 10;

  logic         clk = 1'b0;
  logic         nrst, start_i, abort_i, rk_ready_i;
  logic [127:0] key_i, kg_key_i, kg_key_o, rk_o;
  logic         kg_en_o, kg_gen_key_o, kg_next_rnd_o, rk_valid_o, busy_o, done_o;
  logic [7:0]   kg_rcon_o;
  logic [3:0]   rk_idx_o;

  logic [7:0]   sbox [0:255];
  logic [7:0]   rcon_ref [0:NRND];
  logic [127:0] exp_rk [0:NRND];
  logic [127:0] obs_rk [0:NRND];
  logic [127:0] kg_q = '0;
  int total = 0, bad = 0;
  int done_cycle, keys_seen, en_seen;

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.NRND(NRND)) dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .abort_i(abort_i), .key_i(key_i),
    .kg_key_i(kg_key_i), .kg_key_o(kg_key_o), .kg_en_o(kg_en_o), .kg_gen_key_o(kg_gen_key_o),
    .kg_next_rnd_o(kg_next_rnd_o), .kg_rcon_o(kg_rcon_o), .rk_valid_o(rk_valid_o),
    .rk_ready_i(rk_ready_i), .rk_o(rk_o), .rk_idx_o(rk_idx_o), .busy_o(busy_o), .done_o(done_o)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w3 = k[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Stand-in for the key-gen datapath: one registered round step per enable.
  assign kg_key_i = kg_q;
  always @(posedge clk)
    if (kg_en_o) kg_q <= next_rk(kg_next_rnd_o ? kg_q : kg_key_o, kg_gen_key_o ? kg_rcon_o : 8'h00);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compute_exp(input logic [127:0] key);
    exp_rk[0] = key;
    for (int i = 1; i <= NRND; i++) exp_rk[i] = next_rk(exp_rk[i-1], rcon_ref[i]);
  endtask

  task automatic chk_idle_zero(input string pfx);
    chk({pfx, "_rk"}, rk_o, 128'h0);
    chk({pfx, "_idx"}, 128'(rk_idx_o), 128'h0);
    chk({pfx, "_valid"}, 128'(rk_valid_o), 128'h0);
    chk({pfx, "_busy"}, 128'(busy_o), 128'h0);
    chk({pfx, "_done"}, 128'(done_o), 128'h0);
    chk({pfx, "_en"}, 128'(kg_en_o), 128'h0);
    chk({pfx, "_gen"}, 128'(kg_gen_key_o), 128'h0);
    chk({pfx, "_next"}, 128'(kg_next_rnd_o), 128'h0);
    chk({pfx, "_rcon"}, 128'(kg_rcon_o), 128'h0);
    chk({pfx, "_kgkey"}, kg_key_o, 128'h0);
  endtask

  // Transaction-level schedule model: keys 0..NRND in order, each handshake followed by
  // exactly one enable cycle and the next key one cycle later; done one cycle after the last.
  task automatic sched(input logic [127:0] key, input int stall_idx, input int stall_len,
                       input int start_idx, input int abort_idx, input bit rnd_ready,
                       input bit idle_abort);
    int c, nidx, due_valid, due_en, due_done, end_c, stall_left;
    bit active, exp_valid, ab, hs;
    compute_exp(key);
    start_i = 1'b1; key_i = key; abort_i = idle_abort; rk_ready_i = 1'b0;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    key_i = {$urandom, $urandom, $urandom, $urandom};
    c = 1; nidx = 0; due_valid = 1; due_en = -1; due_done = -1; end_c = -1;
    stall_left = stall_len; active = 1'b1; done_cycle = -1; keys_seen = 0; en_seen = 0;
    while (c < 400 && (end_c < 0 || c <= end_c)) begin
      exp_valid = active && due_valid >= 0 && c >= due_valid;
      chk("busy", 128'(busy_o), 128'(active));
      chk("valid", 128'(rk_valid_o), 128'(exp_valid));
      chk("kg_en", 128'(kg_en_o), 128'(c == due_en));
      chk("done", 128'(done_o), 128'(c == due_done));
      chk("kg_key", kg_key_o, key);
      if (c == due_en) begin
        chk("rcon", 128'(kg_rcon_o), 128'(rcon_ref[nidx]));
        chk("gen_key", 128'(kg_gen_key_o), 128'h1);
        chk("next_rnd", 128'(kg_next_rnd_o), 128'(nidx > 1));
      end else begin
        chk("rcon_idle", 128'(kg_rcon_o), 128'h0);
      end
      if (exp_valid) begin
        chk("rk_idx", 128'(rk_idx_o), 128'(nidx));
        chk("rk", rk_o, exp_rk[nidx]);
        obs_rk[nidx] = rk_o;
      end
      if (kg_en_o) en_seen++;
      if (done_o) done_cycle = c;
      rk_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (exp_valid && nidx == stall_idx && stall_left > 0) begin
        rk_ready_i = 1'b0;
        stall_left--;
      end
      start_i = exp_valid && nidx == start_idx;
      key_i   = ~key;
      ab      = exp_valid && nidx == abort_idx;
      abort_i = ab;
      if (ab) rk_ready_i = 1'b1;
      hs = exp_valid && rk_ready_i && !ab;
      if (ab) begin
        active = 1'b0; due_valid = -1;
      end else if (hs) begin
        if (rk_valid_o) keys_seen++;
        if (nidx < NRND) begin
          nidx++; due_en = c + 1; due_valid = c + 2;
        end else begin
          due_done = c + 1; active = 1'b0; due_valid = -1;
        end
      end
      if (!active && end_c < 0) end_c = c + 3;
      tick();
      c++;
    end
    start_i = 1'b0; abort_i = 1'b0; rk_ready_i = 1'b0;
    if (abort_idx < 0) begin
      chk("keys_total", 128'(keys_seen), 128'(NRND + 1));
      chk("en_total", 128'(en_seen), 128'(NRND));
    end
  endtask

  initial begin
    logic [127:0] fips_key;
    int n;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] inv, x;
      x = 8'(i);
      inv = 8'h01;
      for (int j = 0; j < 254; j++) inv = gmul(inv, x);
      if (i == 0) inv = 8'h00;
      sbox[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon_ref[0] = 8'h00;
    rcon_ref[1] = 8'h01;
    for (int i = 2; i <= NRND; i++) rcon_ref[i] = gmul(rcon_ref[i-1], 8'h02);

    // Reset overrides simultaneous start and abort.
    nrst = 1'b1; start_i = 1'b1; abort_i = 1'b1; rk_ready_i = 1'b1;
    key_i = 128'hdeadbeef_01234567_89abcdef_feedface;
    tick(); tick();
    chk_idle_zero("reset");
    nrst = 1'b0; start_i = 1'b0; abort_i = 1'b0; rk_ready_i = 1'b0;
    tick();

    // FIPS-197 vector, ready held high, abort in IDLE alongside start is a no-op.
    fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    sched(fips_key, -1, 0, -1, -1, 1'b0, 1'b1);
    chk("fips_idx1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_idx10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("done_cycle", 128'(done_cycle), 128'd22);

    // Back-pressure at idx3 for five cycles.
    sched({$urandom, $urandom, $urandom, $urandom}, 3, 5, -1, -1, 1'b0, 1'b0);

    // Start pulsed while idx5 is presented.
    sched({$urandom, $urandom, $urandom, $urandom}, -1, 0, 5, -1, 1'b0, 1'b0);

    // Abort coincident with the idx7 handshake, then a fresh schedule.
    sched({$urandom, $urandom, $urandom, $urandom}, -1, 0, -1, 7, 1'b0, 1'b0);
    chk("abort_no_done", 128'(done_cycle), 128'hffffffff_ffffffff_ffffffff_ffffffff);
    sched({$urandom, $urandom, $urandom, $urandom}, -1, 0, -1, -1, 1'b0, 1'b0);

    // Reset asserted during a key-gen step.
    start_i = 1'b1; key_i = {$urandom, $urandom, $urandom, $urandom}; rk_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    while (kg_en_o !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("calc_reached", 128'(kg_en_o), 128'h1);
    nrst = 1'b1;
    tick();
    nrst = 1'b0;
    chk_idle_zero("mid_reset");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_en", 128'(kg_en_o), 128'h0);
      chk("post_reset_busy", 128'(busy_o), 128'h0);
      chk("post_reset_done", 128'(done_o), 128'h0);
    end
    rk_ready_i = 1'b0;
    sched({$urandom, $urandom, $urandom, $urandom}, -1, 0, -1, -1, 1'b0, 1'b0);

    // Random back-pressure.
    for (int i = 0; i < 3; i++)
      sched({$urandom, $urandom, $urandom, $urandom}, -1, 0, -1, -1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
